// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator that sinks an RGB444 pixel stream
// during the active area and drives registered, mutually aligned VGA outputs.
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset_i,
    input  logic        pixel_valid_i,
    input  logic [11:0] pixel_data_i,
    output logic        pixel_ready_o,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_blank_o,
    output logic [3:0]  vga_r_o,
    output logic [3:0]  vga_g_o,
    output logic [3:0]  vga_b_o,
    output logic        frame_start_o,
    output logic        underflow_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [11:0]   rgb;
    logic          h_end, v_end, active, hs_act, vs_act;

    always_comb begin
        h_end         = h_cnt == H_END;
        v_end         = v_cnt == V_END;
        active        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_act        = (h_cnt >= H_SS) && (h_cnt < H_SE);
        vs_act        = (v_cnt >= V_SS) && (v_cnt < V_SE);
        pixel_ready_o = active && !reset_i;
        frame_start_o = h_end && v_end && !reset_i;
    end

    // Video outputs are registered from the same counter state so they stay aligned
    always_ff @(posedge clk_pixel) begin
        if (reset_i) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            vga_hsync_o <= !H_POL;
            vga_vsync_o <= !V_POL;
            vga_blank_o <= 1'b1;
            rgb         <= '0;
            underflow_o <= 1'b0;
        end else begin
            h_cnt       <= h_end ? '0 : h_cnt + 1'b1;
            v_cnt       <= h_end ? (v_end ? '0 : v_cnt + 1'b1) : v_cnt;
            vga_hsync_o <= hs_act ? H_POL : !H_POL;
            vga_vsync_o <= vs_act ? V_POL : !V_POL;
            vga_blank_o <= !active;
            rgb         <= (active && pixel_valid_i) ? pixel_data_i : '0;
            underflow_o <= underflow_o || (active && !pixel_valid_i);
        end
    end

    assign vga_r_o = rgb[11:8];
    assign vga_g_o = rgb[7:4];
    assign vga_b_o = rgb[3:0];
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized bench comparing the timing generator against a
// raster-position model derived from elapsed cycles since reset.
module tb_video_timing_gen;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk_pixel = 1'b0;
    logic        reset_i, pixel_valid_i;
    logic [11:0] pixel_data_i;
    logic        pixel_ready_o, vga_hsync_o, vga_vsync_o, vga_blank_o;
    logic [3:0]  vga_r_o, vga_g_o, vga_b_o;
    logic        frame_start_o, underflow_o;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .clk_pixel(clk_pixel), .reset_i(reset_i),
        .pixel_valid_i(pixel_valid_i), .pixel_data_i(pixel_data_i),
        .pixel_ready_o(pixel_ready_o), .vga_hsync_o(vga_hsync_o),
        .vga_vsync_o(vga_vsync_o), .vga_blank_o(vga_blank_o),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
        .frame_start_o(frame_start_o), .underflow_o(underflow_o)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          t, x, y, seq, last_fs, xfers;
    bit          act, uf_done;
    logic        e_hs, e_vs, e_bl, e_uf;
    logic [11:0] e_rgb;

    initial begin
        reset_i = 1'b1;
        pixel_valid_i = 1'b0;
        pixel_data_i = '0;
        t = 0; seq = 0; last_fs = -1; xfers = 0; uf_done = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_rgb = '0; e_uf = 1'b0;
        @(posedge clk_pixel);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk_pixel);
            #1;
            check("hsync", vga_hsync_o, e_hs);
            check("vsync", vga_vsync_o, e_vs);
            check("blank", vga_blank_o, e_bl);
            check("rgb", {vga_r_o, vga_g_o, vga_b_o}, e_rgb);
            check("underflow", underflow_o, e_uf);
            t = reset_i ? 0 : (t + 1) % FT;
            x = t % HT;
            y = t / HT;
            act = (x < HA) && (y < VA);
            // Phase 1: clean incrementing stream; phase 2: one missing pixel; then random
            reset_i = (cyc < 3) || (cyc == 1000) || (cyc >= 400 && $urandom_range(0, 149) == 0);
            if (cyc < 400) begin
                pixel_valid_i = !(cyc >= 250 && x == 5 && y == 2 && !uf_done);
                if (cyc >= 250 && x == 5 && y == 2) uf_done = 1;
                pixel_data_i = (x == 1 && y == 0) ? 12'hABC : seq[11:0];
            end else begin
                pixel_valid_i = $urandom_range(0, 4) != 0;
                pixel_data_i = 12'($urandom);
            end
            if (act && pixel_valid_i && !reset_i) seq++;
            #1;
            check("ready", pixel_ready_o, act && !reset_i);
            check("frame_start", frame_start_o, x == HT - 1 && y == VT - 1 && !reset_i);
            if (reset_i) begin
                last_fs = -1;
                xfers = 0;
            end else if (frame_start_o && cyc < 250) begin
                if (last_fs >= 0) begin
                    check("fs_period", cyc - last_fs, FT);
                    check("frame_xfers", xfers, HA * VA);
                end
                last_fs = cyc;
                xfers = 0;
            end
            if (pixel_ready_o && pixel_valid_i) xfers++;
            if (reset_i) begin
                e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_rgb = '0; e_uf = 1'b0;
            end else begin
                e_hs = !(x >= HA + HF && x < HA + HF + HS);
                e_vs = !(y >= VA + VF && y < VA + VF + VS);
                e_bl = !act;
                e_rgb = (act && pixel_valid_i) ? pixel_data_i : 12'h000;
                if (act && !pixel_valid_i) e_uf = 1'b1;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
